cm_sort_tag: RTL and testbench
==============================

Name: cm_sort_tag

Overview:
- Parametrised, pipelined, stable sorting network for the cm library; successor to cm_sort.
- Sorts DCNT keys of DWIDTH bits per transaction using an odd-even transposition network of DCNT compare-exchange stages.
- Adds valid/ready backpressure, a per-transaction ascending/descending mode, optional signed compare, and an original-index tag output.
- Sits between a producer and a consumer that both use vld/rdy streams.

Parameters:
- DCNT, 8, number of elements per transaction; must be >= 2.
- DWIDTH, 8, key width in bits.
- REG_CNT, 1, number of pipeline register slots; range 0..DCNT. 0 = fully combinational.
- SIGNED, 0, 1 = keys compared as two's complement; 0 = unsigned.
- IWIDTH, $clog2(DCNT), width of each index tag (derived).

Ports:
- i_clk  in  1  clock; all registers on rising edge.
- i_rst_n  in  1  asynchronous reset, active low.
- i_vld  in  1  input transaction valid.
- i_rdy  out  1  block accepts an input transaction this cycle.
- i_desc  in  1  mode for this transaction: 0 = ascending, 1 = descending.
- i_data  in  DCNT x DWIDTH  packed keys; element 0 in the least significant slice.
- o_vld  out  1  output transaction valid.
- o_rdy  in  1  consumer accepts the output.
- o_data  out  DCNT x DWIDTH  sorted keys.
- o_idx  out  DCNT x IWIDTH  o_idx[k] = original input position of o_data[k].
- o_desc  out  1  mode the transaction was sorted with.

Behaviour:
- Reset: while i_rst_n = 0, all slot valids clear, so o_vld = 0; all data, idx and desc registers are 0. Release is synchronised internally to i_clk.
- Tag insertion: at input, element k carries tag k. The tag and i_desc travel with the data through every stage.
- Network stage s (0..DCNT-1):
  - Even s compares pairs (0,1),(2,3),...; odd s compares pairs (1,2),(3,4),...
  - Ascending: swap a pair (lo,hi) only if key[lo] > key[hi], strictly.
  - Descending: swap only if key[lo] < key[hi], strictly.
  - Because swaps are strict, equal keys keep input order (stable).
- Compare: signed when SIGNED = 1, unsigned otherwise.
- Register placement: slot j (0..REG_CNT-1) sits after stage floor((j+1)*DCNT/REG_CNT)-1. The last slot always drives the outputs.
- Latency: exactly REG_CNT cycles from input accept to o_vld with no stall.
- Throughput: one transaction per cycle.
- Slot load rule: a slot loads when its upstream is valid and the slot is either empty or its content is being accepted downstream this cycle.
  - i_rdy = ~slot0_vld | slot0_advance.
  - Ready may propagate combinationally from o_rdy to i_rdy.
- Bubbles compress: an empty slot accepts new data even when o_rdy = 0.
- Output hold: while o_vld = 1 and o_rdy = 0, o_data, o_idx and o_desc are stable.
- Input accept and output drain in the same cycle with a full pipe: no transaction is lost or duplicated.
- REG_CNT = 0: o_vld = i_vld, i_rdy = o_rdy, outputs are combinational from inputs; the reset has no effect on data.
- Reset mid-operation: all in-flight transactions are discarded, with no partial output.
- Inputs are don't-care when i_vld = 0. X on unselected data must not reach o_vld.

Test Plan:
- Ascending: DCNT=8, REG_CNT=1, i_desc=0, i_data elements 0..7 = 01,03,A0,00,05,02,03,01.
  -> after 1 cycle, o_data 0..7 = 00,01,01,02,03,03,05,A0; o_idx = 3,0,7,5,1,6,4,2.
- Descending: same data, i_desc=1.
  -> o_data = A0,05,03,03,02,01,01,00; o_idx = 2,4,1,6,5,0,7,3; o_desc=1.
- Signed compare: SIGNED=1, elements 0..7 = 7F,80,00,FF,01,81,7E,00, ascending.
  -> o_data = 80,81,FF,00,00,01,7E,7F; o_idx = 1,5,3,2,7,4,6,0.
- Backpressure: REG_CNT=4, stream 10 random transactions at full rate, hold o_rdy=0 for 6 cycles mid-stream.
  -> i_rdy drops only after all 4 slots are full; outputs stay stable while stalled; a scoreboard sees every transaction once, in order, correctly sorted.
- Latency and edges: sweep REG_CNT = 0, 1, 3, 8 with o_rdy=1.
  -> o_vld rises exactly REG_CNT cycles after accept.
  - All-equal input (all 5A) -> o_idx = 0..7.
  - Already-sorted and reverse-sorted inputs sort correctly.
- Reset mid-stream: assert i_rst_n=0 asynchronously with 3 transactions in flight.
  -> o_vld=0 immediately and outputs are 0; after release, only new transactions appear.

Source files
------------

// File: rtl/cm_sort_tag.sv
// cm_sort_tag -- pipelined, stable odd-even transposition sorter with index tags.
//
// Sorts DCNT keys of DWIDTH bits per transaction through DCNT compare-exchange
// stages. Each key carries its original position (tag) and the transaction's
// sort direction through the network. REG_CNT register slots are spread
// evenly along the stages; the last slot always drives the outputs.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (release synchronised to i_clk)
//   i_vld    input transaction valid
//   i_rdy    block accepts the input transaction this cycle
//   i_desc   0 = ascending, 1 = descending
//   i_data   DCNT packed keys, element 0 in the least significant slice
//   o_vld    output transaction valid
//   o_rdy    consumer accepts the output
//   o_data   sorted keys
//   o_idx    o_idx[k] = original input position of o_data[k]
//   o_desc   direction the transaction was sorted with
//
// Handshake: a transfer happens on a rising edge where vld and rdy are both 1.
// Once o_vld is raised it stays high and o_data/o_idx/o_desc hold until the
// consumer takes the transaction. i_rdy may depend combinationally on o_rdy.
module cm_sort_tag #(
    parameter int DCNT    = 8,
    parameter int DWIDTH  = 8,
    parameter int REG_CNT = 1,
    parameter int SIGNED  = 0,
    parameter int IWIDTH  = $clog2(DCNT)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_vld,
    output logic                     i_rdy,
    input  logic                     i_desc,
    input  logic [DCNT*DWIDTH-1:0]   i_data,
    output logic                     o_vld,
    input  logic                     o_rdy,
    output logic [DCNT*DWIDTH-1:0]   o_data,
    output logic [DCNT*IWIDTH-1:0]   o_idx,
    output logic                     o_desc
);

    localparam int KW = DCNT * DWIDTH;
    localparam int IW = DCNT * IWIDTH;
    localparam int RN = (REG_CNT > 0) ? REG_CNT : 1;

    // Slot index that sits right after stage s, or -1 if none.
    function automatic int slot_at(input int s);
        int r;
        r = -1;
        for (int j = 0; j < REG_CNT; j++) begin
            if (((j + 1) * DCNT) / REG_CNT - 1 == s) r = j;
        end
        return r;
    endfunction

    function automatic logic key_gt(input logic [DWIDTH-1:0] a,
                                    input logic [DWIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    logic          rst_sync_n;
    logic [RN-1:0] slot_vld;
    logic [RN-1:0] slot_load;   // slot captures its upstream this cycle
    logic [RN-1:0] slot_down;   // downstream would take this slot's content

    // ------------------------------------------------------------------
    // Slot control
    // ------------------------------------------------------------------
    if (REG_CNT > 0) begin : g_ctl
        logic [1:0] rst_sync;

        // Assert immediately, release two clocks later.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) rst_sync <= 2'b00;
            else          rst_sync <= {rst_sync[0], 1'b1};
        end
        assign rst_sync_n = rst_sync[1];

        // Ready ripples from the output slot back to the input. A slot can
        // take new data if it is empty or its content moves on this cycle,
        // so empty slots fill even while the consumer stalls.
        always_comb begin
            logic acc;
            logic up;
            acc       = o_rdy;
            up        = 1'b0;
            slot_load = '0;
            slot_down = '0;
            for (int j = REG_CNT - 1; j >= 0; j--) begin
                up           = (j == 0) ? i_vld : slot_vld[(j > 0) ? j - 1 : 0];
                slot_down[j] = acc;
                slot_load[j] = up & (~slot_vld[j] | acc);
                acc          = ~slot_vld[j] | acc;
            end
            // Hold off the producer while the reset release is in progress.
            i_rdy = acc & rst_sync_n;
        end

        always_ff @(posedge i_clk or negedge rst_sync_n) begin
            if (!rst_sync_n) begin
                slot_vld <= '0;
            end else begin
                for (int j = 0; j < REG_CNT; j++) begin
                    if (slot_load[j])      slot_vld[j] <= 1'b1;
                    else if (slot_down[j]) slot_vld[j] <= 1'b0;
                end
            end
        end

        assign o_vld = slot_vld[RN-1];
    end else begin : g_comb
        assign rst_sync_n = 1'b1;
        assign slot_vld   = '0;
        assign slot_load  = '0;
        assign slot_down  = '0;
        assign i_rdy      = o_rdy;
        assign o_vld      = i_vld;
    end

    // ------------------------------------------------------------------
    // Tag insertion: element k starts with tag k.
    // ------------------------------------------------------------------
    logic [IW-1:0] tag_idx;

    always_comb begin
        tag_idx = '0;
        for (int k = 0; k < DCNT; k++) tag_idx[k*IWIDTH +: IWIDTH] = IWIDTH'(k);
    end

    // ------------------------------------------------------------------
    // Network stages, each optionally followed by a register slot.
    // ------------------------------------------------------------------
    for (genvar s = 0; s < DCNT; s++) begin : g_stage
        localparam int SLOT = slot_at(s);

        logic [KW-1:0] in_key, cx_key, nx_key;
        logic [IW-1:0] in_idx, cx_idx, nx_idx;
        logic          in_desc, nx_desc;

        if (s == 0) begin : g_head
            assign in_key  = i_data;
            assign in_idx  = tag_idx;
            assign in_desc = i_desc;
        end else begin : g_link
            assign in_key  = g_stage[s-1].nx_key;
            assign in_idx  = g_stage[s-1].nx_idx;
            assign in_desc = g_stage[s-1].nx_desc;
        end

        // Even stages pair (0,1),(2,3)..; odd stages pair (1,2),(3,4)..
        // Strict comparison keeps equal keys in input order.
        always_comb begin
            logic [DWIDTH-1:0] ka, kb;
            logic [IWIDTH-1:0] ta, tb;
            logic              swap;
            cx_key = in_key;
            cx_idx = in_idx;
            ka     = '0;
            kb     = '0;
            ta     = '0;
            tb     = '0;
            swap   = 1'b0;
            for (int lo = s % 2; lo + 1 < DCNT; lo += 2) begin
                ka   = in_key[lo*DWIDTH +: DWIDTH];
                kb   = in_key[(lo+1)*DWIDTH +: DWIDTH];
                ta   = in_idx[lo*IWIDTH +: IWIDTH];
                tb   = in_idx[(lo+1)*IWIDTH +: IWIDTH];
                swap = in_desc ? key_gt(kb, ka) : key_gt(ka, kb);
                if (swap) begin
                    cx_key[lo*DWIDTH +: DWIDTH]     = kb;
                    cx_key[(lo+1)*DWIDTH +: DWIDTH] = ka;
                    cx_idx[lo*IWIDTH +: IWIDTH]     = tb;
                    cx_idx[(lo+1)*IWIDTH +: IWIDTH] = ta;
                end
            end
        end

        if (SLOT >= 0) begin : g_slot
            always_ff @(posedge i_clk or negedge rst_sync_n) begin
                if (!rst_sync_n) begin
                    nx_key  <= '0;
                    nx_idx  <= '0;
                    nx_desc <= 1'b0;
                end else if (slot_load[SLOT]) begin
                    nx_key  <= cx_key;
                    nx_idx  <= cx_idx;
                    nx_desc <= in_desc;
                end
            end
        end else begin : g_pass
            assign nx_key  = cx_key;
            assign nx_idx  = cx_idx;
            assign nx_desc = in_desc;
        end
    end

    assign o_data = g_stage[DCNT-1].nx_key;
    assign o_idx  = g_stage[DCNT-1].nx_idx;
    assign o_desc = g_stage[DCNT-1].nx_desc;

endmodule

// File: tb/tb_cm_sort_tag.sv
// tb_cm_sort_tag -- bench for cm_sort_tag.
//
// Six instances share one driver: REG_CNT 0,1,3,4,8 unsigned and REG_CNT 1
// signed. Only the selected instance sees i_vld; the others drain freely.
// Expected results come from a stable insertion-sort model or constants.
module tb_cm_sort_tag;

    localparam int W  = 8*8 + 8*3 + 1;   // {desc, idx, data}
    localparam int NC = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        drv_vld, drv_desc, drv_ordy;
    logic [63:0] drv_data;
    logic [W-1:0] drv_exp;
    int          sel;

    logic        u_ivld  [NC];
    logic        u_irdy  [NC];
    logic        u_ovld  [NC];
    logic        u_ordy  [NC];
    logic        u_odesc [NC];
    logic [63:0] u_odata [NC];
    logic [23:0] u_oidx  [NC];

    for (genvar c = 0; c < NC; c++) begin : g_dut
        localparam int RC = (c == 0) ? 0 : (c == 1) ? 1 : (c == 2) ? 3 :
                            (c == 3) ? 4 : (c == 4) ? 8 : 1;
        localparam int SG = (c == 5) ? 1 : 0;

        assign u_ivld[c] = drv_vld && (sel == c);
        assign u_ordy[c] = (sel == c) ? drv_ordy : 1'b1;

        cm_sort_tag #(
            .DCNT(8), .DWIDTH(8), .REG_CNT(RC), .SIGNED(SG)
        ) u_dut (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .i_vld  (u_ivld[c]),
            .i_rdy  (u_irdy[c]),
            .i_desc (drv_desc),
            .i_data (drv_data),
            .o_vld  (u_ovld[c]),
            .o_rdy  (u_ordy[c]),
            .o_data (u_odata[c]),
            .o_idx  (u_oidx[c]),
            .o_desc (u_odesc[c])
        );
    end

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    int           cyc_q[$];
    int           n_chk, n_fail, cyc;
    bit           chk_rdy, chk_lat, prev_stall, acc;
    logic [W-1:0] prev_out;

    function automatic int rc_of(input int c);
        case (c)
            0: return 0;
            1: return 1;
            2: return 3;
            3: return 4;
            4: return 8;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d, cycle %0d): got %h expected %h",
                     tag, sel, cyc, got, exp);
        end
    endtask

    // Stable reference sort: insertion sort with strict comparison.
    function automatic logic [W-1:0] model(input logic [63:0] d,
                                           input logic desc, input logic sgn);
        int k[8];
        int ix[8];
        int t;
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) begin
            k[i]  = sgn ? int'($signed(d[i*8 +: 8])) : int'(d[i*8 +: 8]);
            ix[i] = i;
        end
        for (int i = 1; i < 8; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (k[j] > k[j-1]) : (k[j] < k[j-1])) begin
                    t = k[j];  k[j]  = k[j-1];  k[j-1]  = t;
                    t = ix[j]; ix[j] = ix[j-1]; ix[j-1] = t;
                end else begin
                    break;
                end
            end
        end
        r = '0;
        r[W-1] = desc;
        for (int i = 0; i < 8; i++) begin
            r[i*8 +: 8]      = k[i][7:0];
            r[64 + i*3 +: 3] = ix[i][2:0];
        end
        return r;
    endfunction

    function automatic logic [23:0] pk_idx(input int a0, input int a1,
        input int a2, input int a3, input int a4, input int a5, input int a6,
        input int a7);
        int v[8];
        logic [23:0] r;
        v = '{a0, a1, a2, a3, a4, a5, a6, a7};
        r = '0;
        for (int i = 0; i < 8; i++) r[i*3 +: 3] = v[i][2:0];
        return r;
    endfunction

    function automatic logic [63:0] rnd_data();
        logic [63:0] d;
        bit narrow;
        narrow = ($urandom_range(0, 1) == 1);
        for (int i = 0; i < 8; i++)
            d[i*8 +: 8] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
        return d;
    endfunction

    // ------------------------------------------------------------------
    // One clock of driving and checking. Entered just after a rising edge.
    // ------------------------------------------------------------------
    task automatic step();
        logic [W-1:0] got, exp;
        int inflight, c0;
        @(negedge clk);
        inflight = exp_q.size();
        acc = drv_vld && u_irdy[sel];
        if (chk_rdy)
            check("i_rdy", W'(u_irdy[sel]), W'(drv_ordy || (inflight < rc_of(sel))));
        if (acc) begin
            exp_q.push_back(drv_exp);
            cyc_q.push_back(cyc);
        end
        got = {u_odesc[sel], u_oidx[sel], u_odata[sel]};
        if (prev_stall) begin
            check("hold_vld", W'(u_ovld[sel]), W'(1));
            check("hold_out", got, prev_out);
        end
        if (u_ovld[sel] && drv_ordy) begin
            if (exp_q.size() == 0) begin
                check("spurious_vld", W'(u_ovld[sel]), W'(0));
            end else begin
                exp = exp_q.pop_front();
                c0  = cyc_q.pop_front();
                check("sorted", got, exp);
                if (chk_lat) check("latency", W'(cyc - c0), W'(rc_of(sel)));
            end
        end
        prev_stall = u_ovld[sel] && !drv_ordy;
        prev_out   = got;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [63:0] d, input logic desc,
                        input logic [W-1:0] e);
        int t;
        t = 0;
        drv_vld  = 1'b1;
        drv_data = d;
        drv_desc = desc;
        drv_exp  = e;
        acc      = 1'b0;
        while (!acc && t < 50) begin
            step();
            t++;
        end
        if (!acc) check("send_timeout", W'(acc), W'(1));
        drv_vld = 1'b0;
    endtask

    task automatic send_model(input logic [63:0] d, input logic desc);
        send(d, desc, model(d, desc, sel == 5));
    endtask

    task automatic drain();
        int t;
        t = 0;
        drv_vld  = 1'b0;
        drv_ordy = 1'b1;
        while (exp_q.size() > 0 && t < 40) begin
            step();
            t++;
        end
        check("drain_empty", W'(exp_q.size()), W'(0));
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [63:0] d;
        int sent, t;
        int sweep[4];

        n_chk = 0; n_fail = 0; cyc = 0;
        chk_rdy = 0; chk_lat = 0; prev_stall = 0; acc = 0;
        prev_out = '0;
        sel = 1;
        drv_vld = 0; drv_desc = 0; drv_ordy = 1; drv_data = '0; drv_exp = '0;
        rst_n = 0;

        // Reset state of every registered instance.
        repeat (3) @(negedge clk);
        for (int c = 1; c < NC; c++) begin
            check("rst_vld", W'(u_ovld[c]), W'(0));
            check("rst_out", {u_odesc[c], u_oidx[c], u_odata[c]}, '0);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        repeat (3) step();
        chk_rdy = 1;
        chk_lat = 1;

        // Directed ascending / descending, REG_CNT = 1.
        sel = 1;
        send(64'h01_03_02_05_00_A0_03_01, 1'b0,
             {1'b0, pk_idx(3, 0, 7, 5, 1, 6, 4, 2), 64'hA0_05_03_03_02_01_01_00});
        send(64'h01_03_02_05_00_A0_03_01, 1'b1,
             {1'b1, pk_idx(2, 4, 1, 6, 5, 0, 7, 3), 64'h00_01_01_02_03_03_05_A0});
        drain();

        // Signed compare.
        sel = 5;
        send(64'h00_7E_81_01_FF_00_80_7F, 1'b0,
             {1'b0, pk_idx(1, 5, 3, 2, 7, 4, 6, 0), 64'h7F_7E_01_00_00_FF_81_80});
        for (int i = 0; i < 4; i++) send_model(rnd_data(), 1'($urandom_range(0, 1)));
        drain();

        // Latency and edge patterns across REG_CNT = 0, 1, 3, 8.
        sweep = '{0, 1, 2, 4};
        for (int s = 0; s < 4; s++) begin
            sel = sweep[s];
            send(64'h5A5A5A5A5A5A5A5A, 1'b0,
                 {1'b0, pk_idx(0, 1, 2, 3, 4, 5, 6, 7), 64'h5A5A5A5A5A5A5A5A});
            drain();
            send(64'h5A5A5A5A5A5A5A5A, 1'b1,
                 {1'b1, pk_idx(0, 1, 2, 3, 4, 5, 6, 7), 64'h5A5A5A5A5A5A5A5A});
            drain();
            send_model(64'h08_07_06_05_04_03_02_01, 1'b0);
            drain();
            send_model(64'h01_02_03_04_05_06_07_08, 1'b0);
            drain();
            send_model(64'h08_07_06_05_04_03_02_01, 1'b1);
            for (int i = 0; i < 5; i++) send_model(rnd_data(), 1'($urandom_range(0, 1)));
            drain();
        end

        // Backpressure on REG_CNT = 4: full-rate stream, 6-cycle stall.
        sel = 3;
        chk_lat = 0;
        sent = 0;
        t = 0;
        d = rnd_data();
        drv_desc = 1'($urandom_range(0, 1));
        while (sent < 10 && t < 100) begin
            drv_vld  = 1'b1;
            drv_data = d;
            drv_exp  = model(d, drv_desc, 1'b0);
            drv_ordy = !(t >= 3 && t < 9);
            step();
            if (acc) begin
                sent++;
                d = rnd_data();
                drv_desc = 1'($urandom_range(0, 1));
            end
            t++;
        end
        check("bp_sent", W'(sent), W'(10));
        drain();

        // Reset with three transactions in flight.
        drv_ordy = 1'b0;
        for (int i = 0; i < 3; i++) send_model(rnd_data(), 1'($urandom_range(0, 1)));
        #2;
        rst_n = 0;
        #1;
        check("mid_rst_vld", W'(u_ovld[sel]), W'(0));
        check("mid_rst_out", {u_odesc[sel], u_oidx[sel], u_odata[sel]}, '0);
        exp_q.delete();
        cyc_q.delete();
        prev_stall = 0;
        chk_rdy    = 0;
        drv_ordy   = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) step();
        rst_n = 1;
        repeat (3) step();
        chk_rdy = 1;
        chk_lat = 1;
        repeat (4) step();
        for (int i = 0; i < 3; i++) send_model(rnd_data(), 1'($urandom_range(0, 1)));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
